// File: rtl/mcalu_pkg.sv
// Shared types and elaboration helpers for the serial multi-cycle ALU.
package mcalu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_XOR  = 3'b010,
    OP_SLT  = 3'b011,
    OP_AND  = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_OR   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // SUB and SLT both run the adder as a + ~b + 1
  function automatic logic op_is_sub(input op_e o);
    return (o == OP_SUB) || (o == OP_SLT);
  endfunction

  function automatic logic op_is_arith(input op_e o);
    return (o == OP_ADD) || op_is_sub(o);
  endfunction

  function automatic logic chunk_legal(input int unsigned w, input int unsigned c);
    return (c >= 1) && (c <= w) && ((w % c) == 0);
  endfunction

endpackage

// File: rtl/mcalu_chunk.sv
// Combinational CHUNK-bit ALU slice; logic-op gates exist only when
// MCALU_LOGIC_OPS_EN is defined.
module mcalu_chunk
  import mcalu_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_s,
  input  logic [CHUNK-1:0] b_s,
  input  logic             cin,
  input  op_e              op,
  output logic [CHUNK-1:0] res_s,
  output logic             cout,
  output logic             cin_msb
);

  localparam int unsigned SW = CHUNK + 1;

  logic [CHUNK-1:0] bx;
  logic [CHUNK:0]   sum;

  always_comb begin
    bx      = b_s ^ {CHUNK{op_is_sub(op)}};
    sum     = {1'b0, a_s} + {1'b0, bx} + SW'(cin);
    res_s   = '0;
    cout    = 1'b0;
    cin_msb = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SLT: begin
        res_s   = sum[CHUNK-1:0];
        cout    = sum[CHUNK];
        // carry into the top bit recovered from its sum bit
        cin_msb = a_s[CHUNK-1] ^ bx[CHUNK-1] ^ sum[CHUNK-1];
      end
`ifdef MCALU_LOGIC_OPS_EN
      OP_XOR:  res_s = a_s ^ b_s;
      OP_AND:  res_s = a_s & b_s;
      OP_NAND: res_s = ~(a_s & b_s);
      OP_NOR:  res_s = ~(a_s | b_s);
      OP_OR:   res_s = a_s | b_s;
`endif
      default: res_s = '0;
    endcase
  end

endmodule

// File: rtl/mcalu_serial.sv
// Multi-cycle ALU: WIDTH-bit operands processed CHUNK bits per clock through
// one shared slice. Logic ops enabled by MCALU_LOGIC_OPS_EN.
module mcalu_serial
  import mcalu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!chunk_legal(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("mcalu_serial: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic               accept, step, last;
  logic [WIDTH-1:0]   a_q, b_q;
  op_e                op_q, op_in;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [31:0]        base;
  logic [CHUNK-1:0]   res_s;
  logic               cout, cin_msb;
  logic               ovf_w;
  logic [WIDTH-1:0]   res_w, res_fin;

  assign op_in = op_e'(op);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign base = 32'(cnt_q) * CHUNK;

  mcalu_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_s     (a_q[base +: CHUNK]),
    .b_s     (b_q[base +: CHUNK]),
    .cin     (carry_q),
    .op      (op_q),
    .res_s   (res_s),
    .cout    (cout),
    .cin_msb (cin_msb)
  );

  // Merge the slice into the result; SLT replaces it on the final chunk
  always_comb begin
    res_w                = result;
    res_w[base +: CHUNK] = res_s;
    ovf_w                = op_is_arith(op_q) & (cin_msb ^ cout);
    res_fin              = res_w;
    if (op_q == OP_SLT) res_fin = WIDTH'(res_w[WIDTH-1] ^ ovf_w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        op_q    <= op_in;
        cnt_q   <= '0;
        carry_q <= op_is_sub(op_in);
      end
      if (step) begin
        carry_q <= cout;
        cnt_q   <= cnt_q + CNT_W'(1);
        result  <= last ? res_fin : res_w;
        if (last) begin
          carryout <= op_is_arith(op_q) & cout;
          overflow <= ovf_w;
          zero     <= (res_fin == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_mcalu_serial.sv
// Randomised self-checking bench for mcalu_serial (WIDTH=32, CHUNK=4),
// compared against an arithmetic reference model.
module tb_mcalu_serial;

  localparam int NCHUNK = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        carryout, overflow, zero;

  int n_checks = 0;
  int n_errors = 0;

  mcalu_serial #(.WIDTH(32), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryout  (carryout),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from plain two's-complement arithmetic
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic c, output logic v,
                                output logic z);
    logic [32:0] s;
    r = 32'd0;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'b000: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0];
        c = s[32];
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      3'b001, 3'b011: begin
        r = x - y;
        c = (x >= y);
        v = (x[31] != y[31]) && (r[31] != x[31]);
        if (o == 3'b011) r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      end
`ifdef MCALU_LOGIC_OPS_EN
      3'b010: r = x ^ y;
      3'b100: r = x & y;
      3'b101: r = ~(x & y);
      3'b110: r = ~(x | y);
      3'b111: r = x | y;
`endif
      default: r = 32'd0;
    endcase
    z = (r == 32'd0);
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    logic [31:0] er;
    logic ec, ev, ez;
    int n;
    model(o, x, y, er, ec, ev, ez);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    a = x;
    b = y;
    op = o;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(NCHUNK));
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, carryout, ec);
    check({tag, "_ovf"}, overflow, ev);
    check({tag, "_zero"}, zero, ez);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom;
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_ready"}, in_ready, 0);
      check({tag, "_hold_flags"}, {result, carryout, overflow, zero}, {er, ec, ev, ez});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, out_valid, 0);
    check({tag, "_rel_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] pool [5];
    logic [31:0] x, y;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    repeat (3) @(negedge clk);
    check("rst_state", {out_valid, in_ready, result, carryout, overflow, zero}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    run_op("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op("sub_zero", 3'b001, 32'h0000_0005, 32'h0000_0005, 0);
    run_op("sub_ovf", 3'b001, 32'h8000_0000, 32'h0000_0001, 1);
    run_op("slt_neg", 3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("slt_ovf", 3'b011, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    run_op("slt_eq", 3'b011, 32'd3, 32'd3, 0);
    run_op("bp", 3'b000, 32'h1234_5678, 32'h1111_1111, 5);
    run_op("xor", 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 2);

    // Reset while the counter sits at chunk 3
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    op = 3'b000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_result", result, 32'd0);
    check("midrst_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready", in_ready, 1);
    run_op("post_rst_add", 3'b000, 32'd2, 32'd3, 0);

    pool[0] = 32'h0000_0000;
    pool[1] = 32'hFFFF_FFFF;
    pool[2] = 32'h8000_0000;
    pool[3] = 32'h7FFF_FFFF;
    pool[4] = 32'h0000_0001;
    for (int k = 0; k < 40; k++) begin
      x = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 7) == 0) y = x;
      run_op($sformatf("rnd%0d", k), 3'($urandom), x, y, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
